// File: rtl/uart_resp_pkg.sv
// Shared encodings for the UART byte-command responder:
// FSM states, command opcodes and reply bytes.
package uart_resp_pkg;

  typedef enum logic [2:0] {
    IDLE,
    GET_ADDR,
    GET_DATA,
    TX_REQ,
    TX_WAIT
  } state_t;

  localparam logic [7:0] OP_WRITE = 8'h57;
  localparam logic [7:0] OP_READ  = 8'h52;
  localparam logic [7:0] RSP_ACK  = 8'h4B;
  localparam logic [7:0] RSP_NAK  = 8'h3F;

endpackage

// File: rtl/uart_resp_if.sv
// Receiver/transmitter handshake and status bundle between the UART core
// and the command responder.
interface uart_resp_if;

  logic       rxDone;
  logic       rxErr;
  logic [7:0] rxData;
  logic       txBusy;
  logic       txDone;
  logic       txStart;
  logic [7:0] txIn;
  logic [7:0] ctrl;
  logic       cmdErr;

  modport master (
    input  rxDone, rxErr, rxData, txBusy, txDone,
    output txStart, txIn, ctrl, cmdErr
  );

  modport slave (
    output rxDone, rxErr, rxData, txBusy, txDone,
    input  txStart, txIn, ctrl, cmdErr
  );

endinterface

// File: rtl/uart_resp_sync.sv
// Two-flop synchroniser followed by a rising-edge detector; the pulse
// is one clk wide.
module uart_resp_sync (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic rise
);

  logic [2:0] sr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sr <= '0;
    end else begin
      sr <= {sr[1:0], d};
    end
  end

  assign rise = sr[1] & ~sr[2];

endmodule

// File: rtl/uart_cmd_responder.sv
// Byte-command register responder behind a UART core.
// Define UART_RESP_TIMEOUT_EN to abandon stalled partial commands.
module uart_cmd_responder
  import uart_resp_pkg::*;
#(
  parameter int ADDR_W         = 4,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input logic       clk,
  input logic       reset,
  uart_resp_if.master bus
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic rx_rise;
  logic err_rise;
  logic busy_rise;
  logic done_rise;
  logic rx_any;

  uart_resp_sync u_sync_rx (
    .clk(clk), .reset(reset), .d(bus.rxDone), .rise(rx_rise)
  );
  uart_resp_sync u_sync_err (
    .clk(clk), .reset(reset), .d(bus.rxErr), .rise(err_rise)
  );
  uart_resp_sync u_sync_busy (
    .clk(clk), .reset(reset), .d(bus.txBusy), .rise(busy_rise)
  );
  uart_resp_sync u_sync_done (
    .clk(clk), .reset(reset), .d(bus.txDone), .rise(done_rise)
  );

  assign rx_any = rx_rise | err_rise;

  state_t            state, state_n;
  logic              is_wr, is_wr_n;
  logic [ADDR_W-1:0] addr, addr_n;
  logic [7:0]        tx_byte, tx_byte_n;
  logic              err, err_n;
  logic              we;
  logic              timeout;
  logic [7:0]        regs [DEPTH];

`ifdef UART_RESP_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] tmo_cnt;

  assign timeout = (tmo_cnt == CW'(TIMEOUT_CYCLES));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tmo_cnt <= '0;
    end else if ((state != GET_ADDR && state != GET_DATA)
                 || rx_any || timeout) begin
      tmo_cnt <= '0;
    end else begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_n   = state;
    is_wr_n   = is_wr;
    addr_n    = addr;
    tx_byte_n = tx_byte;
    err_n     = 1'b0;
    we        = 1'b0;
    unique case (state)
      IDLE: begin
        if (err_rise) begin
          state_n   = TX_REQ;
          tx_byte_n = RSP_NAK;
          err_n     = 1'b1;
        end else if (rx_rise) begin
          if (bus.rxData == OP_WRITE || bus.rxData == OP_READ) begin
            state_n = GET_ADDR;
            is_wr_n = (bus.rxData == OP_WRITE);
          end else begin
            state_n   = TX_REQ;
            tx_byte_n = RSP_NAK;
            err_n     = 1'b1;
          end
        end
      end
      GET_ADDR: begin
        if (err_rise) begin
          state_n   = TX_REQ;
          tx_byte_n = RSP_NAK;
          err_n     = 1'b1;
        end else if (rx_rise) begin
          addr_n = bus.rxData[ADDR_W-1:0];
          if (is_wr) begin
            state_n = GET_DATA;
          end else begin
            state_n   = TX_REQ;
            tx_byte_n = regs[bus.rxData[ADDR_W-1:0]];
          end
        end else if (timeout) begin
          state_n = IDLE;
        end
      end
      GET_DATA: begin
        if (err_rise) begin
          state_n   = TX_REQ;
          tx_byte_n = RSP_NAK;
          err_n     = 1'b1;
        end else if (rx_rise) begin
          we        = 1'b1;
          state_n   = TX_REQ;
          tx_byte_n = RSP_ACK;
        end else if (timeout) begin
          state_n = IDLE;
        end
      end
      TX_REQ: begin
        // Bytes arriving while a reply is pending are dropped and flagged
        err_n = rx_any;
        if (busy_rise) begin
          state_n = TX_WAIT;
        end
      end
      TX_WAIT: begin
        err_n = rx_any;
        if (done_rise) begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      is_wr   <= 1'b0;
      addr    <= '0;
      tx_byte <= '0;
      err     <= 1'b0;
    end else begin
      state   <= state_n;
      is_wr   <= is_wr_n;
      addr    <= addr_n;
      tx_byte <= tx_byte_n;
      err     <= err_n;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else if (we) begin
      regs[addr] <= bus.rxData;
    end
  end

  assign bus.txStart = (state == TX_REQ);
  assign bus.txIn    = tx_byte;
  assign bus.ctrl    = regs[0];
  assign bus.cmdErr  = err;

endmodule
